// File: rtl/byte_striping_2l_pkg.sv
// Shared constants for the two-lane word striper.
package byte_striping_2l_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int NUM_LANES      = 2;
  localparam int LANE_RST_VAL   = 0;
  localparam int LANE_INC_W     = $clog2(NUM_LANES + 1);
endpackage

// File: rtl/byte_striping_stage.sv
// Staging register and per-window sel pointer; holds the first word of a window.
module byte_striping_stage
  import byte_striping_2l_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic                  phase,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] stg,
  output logic                  stg_v,
  output logic                  sel
);

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      stg   <= '0;
      stg_v <= 1'b0;
      sel   <= 1'b0;
    end else if (!phase) begin
      if (valid_in) begin
        stg   <= data_in;
        stg_v <= 1'b1;
        sel   <= 1'b1;
      end else begin
        stg_v <= 1'b0;
        sel   <= 1'b0;
      end
    end else begin
      // window end: staged word has been handed to the lanes
      stg_v <= 1'b0;
      sel   <= 1'b0;
    end
  end

endmodule

// File: rtl/byte_striping_2l.sv
// Two-lane word striper: full-rate input, lanes updated once per two-cycle window.
module byte_striping_2l
  import byte_striping_2l_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] lane_0,
  output logic [DATA_WIDTH-1:0] lane_1,
  output logic                  valid_0,
  output logic                  valid_1,
  output logic                  phase,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  localparam logic [DATA_WIDTH-1:0] LANE_RST = DATA_WIDTH'(LANE_RST_VAL);

  logic [DATA_WIDTH-1:0] stg;
  logic                  stg_v;
  logic                  sel;
  logic [DATA_WIDTH-1:0] nxt_l0, nxt_l1;
  logic                  nxt_v0, nxt_v1;
  logic [LANE_INC_W-1:0] inc;

  byte_striping_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
    .clk_2f  (clk_2f),
    .reset   (reset),
    .phase   (phase),
    .data_in (data_in),
    .valid_in(valid_in),
    .stg     (stg),
    .stg_v   (stg_v),
    .sel     (sel)
  );

  // sel picks the lane for a word arriving in the phase=1 cycle, so a
  // lone word always lands on lane_0 and valid_1 never rises without valid_0
  always_comb begin
    nxt_l0 = LANE_RST;
    nxt_l1 = LANE_RST;
    nxt_v0 = 1'b0;
    nxt_v1 = 1'b0;
    if (stg_v) begin
      nxt_l0 = stg;
      nxt_v0 = 1'b1;
    end
    if (valid_in) begin
      if (sel) begin
        nxt_l1 = data_in;
        nxt_v1 = 1'b1;
      end else begin
        nxt_l0 = data_in;
        nxt_v0 = 1'b1;
      end
    end
    inc = LANE_INC_W'(nxt_v0) + LANE_INC_W'(nxt_v1);
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      phase    <= 1'b0;
      lane_0   <= LANE_RST;
      lane_1   <= LANE_RST;
      valid_0  <= 1'b0;
      valid_1  <= 1'b0;
      word_cnt <= '0;
    end else begin
      phase <= ~phase;
      if (phase) begin
        lane_0   <= nxt_l0;
        lane_1   <= nxt_l1;
        valid_0  <= nxt_v0;
        valid_1  <= nxt_v1;
        word_cnt <= word_cnt + CNT_WIDTH'(inc);
      end
    end
  end

endmodule

// File: tb/tb_byte_striping_2l.sv
// Directed self-checking bench for byte_striping_2l.
module tb_byte_striping_2l;
  logic        clk_2f = 1'b0;
  logic        reset  = 1'b1;
  logic [31:0] data_in  = '0;
  logic        valid_in = 1'b0;
  logic [31:0] lane_0, lane_1;
  logic        valid_0, valid_1, phase;
  logic [7:0]  word_cnt;

  int total = 0;
  int bad   = 0;

  byte_striping_2l #(.DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
    .clk_2f  (clk_2f),
    .reset   (reset),
    .data_in (data_in),
    .valid_in(valid_in),
    .lane_0  (lane_0),
    .lane_1  (lane_1),
    .valid_0 (valid_0),
    .valid_1 (valid_1),
    .phase   (phase),
    .word_cnt(word_cnt)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one cycle's input, then sample 1 time unit after the closing edge
  task automatic cyc(input logic [31:0] d, input logic v);
    data_in  = d;
    valid_in = v;
    @(posedge clk_2f);
    #1;
  endtask

  task automatic chk_lanes(input string tag, input logic [31:0] l0, input logic [31:0] l1,
                           input logic v0, input logic v1);
    chk({tag, "_l0"}, {32'h0, lane_0}, {32'h0, l0});
    chk({tag, "_l1"}, {32'h0, lane_1}, {32'h0, l1});
    chk({tag, "_v"}, {62'h0, valid_0, valid_1}, {62'h0, v0, v1});
  endtask

  initial begin
    #12;
    chk_lanes("rst", 32'h0, 32'h0, 1'b0, 1'b0);
    chk("rst_phase", {63'h0, phase}, 64'h0);
    chk("rst_cnt", {56'h0, word_cnt}, 64'h0);
    @(negedge clk_2f);
    reset = 1'b0;
    #1;
    chk("first_phase", {63'h0, phase}, 64'h0);

    // continuous stream
    cyc(32'h11111111, 1'b1);
    chk("p_after1", {63'h0, phase}, 64'h1);
    chk_lanes("s1_hold", 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(32'h22222222, 1'b1);
    chk_lanes("s_pair1", 32'h11111111, 32'h22222222, 1'b1, 1'b1);
    chk("s_cnt2", {56'h0, word_cnt}, 64'd2);
    cyc(32'h33333333, 1'b1);
    chk_lanes("s_pair1_stable", 32'h11111111, 32'h22222222, 1'b1, 1'b1);
    cyc(32'h44444444, 1'b1);
    chk_lanes("s_pair2", 32'h33333333, 32'h44444444, 1'b1, 1'b1);
    chk("s_cnt4", {56'h0, word_cnt}, 64'd4);

    // bubble then word in phase=1
    cyc(32'hFFFFFFFF, 1'b0);
    chk_lanes("b0_hold", 32'h33333333, 32'h44444444, 1'b1, 1'b1);
    cyc(32'hAAAA5555, 1'b1);
    chk_lanes("b0_word", 32'hAAAA5555, 32'h0, 1'b1, 1'b0);
    chk("b0_cnt", {56'h0, word_cnt}, 64'd5);

    // word in phase=0, bubble in phase=1
    cyc(32'hDEADBEEF, 1'b1);
    cyc(32'h12121212, 1'b0);
    chk_lanes("b1_word", 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
    chk("b1_cnt", {56'h0, word_cnt}, 64'd6);

    // idle window
    cyc(32'h0, 1'b0);
    chk_lanes("idle_hold", 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
    cyc(32'h0, 1'b0);
    chk_lanes("idle", 32'h0, 32'h0, 1'b0, 1'b0);
    chk("idle_cnt", {56'h0, word_cnt}, 64'd6);

    // async reset mid-window with a staged word
    cyc(32'h01020304, 1'b1);
    cyc(32'h05060708, 1'b1);
    chk_lanes("pre_rst", 32'h01020304, 32'h05060708, 1'b1, 1'b1);
    chk("pre_rst_cnt", {56'h0, word_cnt}, 64'd8);
    cyc(32'h0BADF00D, 1'b1);
    valid_in = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk_lanes("arst", 32'h0, 32'h0, 1'b0, 1'b0);
    chk("arst_phase", {63'h0, phase}, 64'h0);
    chk("arst_cnt", {56'h0, word_cnt}, 64'h0);
    @(posedge clk_2f);
    @(negedge clk_2f);
    reset = 1'b0;
    #1;
    chk("rel_phase", {63'h0, phase}, 64'h0);
    cyc(32'h0, 1'b0);
    cyc(32'h0, 1'b0);
    chk_lanes("no_stale", 32'h0, 32'h0, 1'b0, 1'b0);
    chk("no_stale_cnt", {56'h0, word_cnt}, 64'h0);

    // 130 full windows, counter wraps 0xFE -> 0x00 -> 0x04
    for (int w = 1; w <= 130; w++) begin
      cyc(32'hA0000000 | (w << 1), 1'b1);
      cyc(32'hB0000000 | ((w << 1) + 1), 1'b1);
      if (w == 127) chk("wrap_fe", {56'h0, word_cnt}, 64'hFE);
      if (w == 128) chk("wrap_00", {56'h0, word_cnt}, 64'h00);
    end
    chk("wrap_04", {56'h0, word_cnt}, 64'h04);
    chk_lanes("wrap_last", 32'hA0000104, 32'hB0000105, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/byte_striping_2l.md
Name: byte_striping_2l

Overview:
Two-lane word striper, the stage directly upstream of the byte unstriping block. It accepts a serial word stream at full rate on one clock (clk_2f) and distributes consecutive valid words alternately onto lane_0/lane_1. It presents both lanes together once per two-cycle window, i.e. at half rate, matching the unstriper's clk_f lane interface.
It generates its own half-rate phase internally, so no second clock is needed.

Parameters:
DATA_WIDTH, 32, width of data_in and of each lane
CNT_WIDTH, 8, width of the transmitted-word counter

Ports:
clk_2f  input  1  sole clock, full word rate; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  DATA_WIDTH  input word
valid_in  input  1  data_in valid this cycle
lane_0  output  DATA_WIDTH  first word of pair
lane_1  output  DATA_WIDTH  second word of pair
valid_0  output  1  lane_0 holds a valid word
valid_1  output  1  lane_1 holds a valid word
phase  output  1  half-rate phase; lanes update on edges where phase==1 (clk_f-equivalent)
word_cnt  output  CNT_WIDTH  count of valid words emitted on lanes, wraps

Behaviour:
- Reset (async, active-high): lane_0=0, lane_1=0, valid_0=0, valid_1=0, phase=0, word_cnt=0; internal stg=0, stg_v=0, sel=0. Reset asserted mid-window discards any staged word.
- phase toggles every clk_2f edge after reset deassertion. The first cycle after reset has phase=0.
- Window = two consecutive cycles: phase=0 cycle, then phase=1 cycle. The lane registers update only at the rising edge that ends a phase=1 cycle. Otherwise they hold, so each lane value is stable for 2 cycles.
- Compaction: the sel pointer counts valid words within the current window. Invalid cycles create no lane gap.
- Phase=0 cycle, valid_in=1: stg<=data_in, stg_v<=1, sel<=1.
- Phase=0 cycle, valid_in=0: stg_v<=0, sel<=0. stg holds its value (don't care).
- Phase=1 cycle, window-end edge, four cases by (stg_v, valid_in):
  - (1,1): lane_0<=stg, lane_1<=data_in, valid_0=1, valid_1=1.
  - (1,0): lane_0<=stg, valid_0=1, lane_1<=0, valid_1=0.
  - (0,1): lane_0<=data_in, valid_0=1, lane_1<=0, valid_1=0. A single word always lands on lane_0.
  - (0,0): lanes<=0, valids<=0.
  - In all cases sel<=0 and stg_v<=0 at the window end.
- Invariant: valid_1=1 implies valid_0=1. The unstriper relies on this.
- Latency:
  - A word accepted in a phase=0 cycle appears on its lane after 2 edges.
  - A word accepted in a phase=1 cycle appears after 1 edge.
- word_cnt increments by valid_0+valid_1 at each window-end edge. Width CNT_WIDTH, modulo 2^CNT_WIDTH wrap, no saturation.
- Invalid lanes are driven to 0, never stale data.
- No backpressure. Input is accepted every cycle, and at most 2 words per window by construction.

Decomposition:
- Shared package: DATA_WIDTH default, lane count constant (2), lane-reset value constant (0).
- A single module is natural. The optional sub-module byte_striping_stage holds the staging register plus sel pointer. The top level holds the phase toggle, lane registers and counter.

Test Plan:
- Reset asserted async mid-cycle with valid data staged -> all outputs 0 immediately. After release, phase=0 on first cycle; a staged word is never emitted.
- Continuous stream 0x11111111, 0x22222222, 0x33333333, 0x44444444 from the first phase=0 cycle -> lane_0=0x11111111, lane_1=0x22222222, valid_0/valid_1=1 for 2 cycles; then 0x33333333/0x44444444; word_cnt=4.
- Bubble in phase=0, word 0xAAAA5555 in phase=1 -> lane_0=0xAAAA5555, valid_0=1, lane_1=0, valid_1=0; word_cnt +1.
- Word 0xDEADBEEF in phase=0, bubble in phase=1 -> lane_0=0xDEADBEEF, valid_0=1, valid_1=0, lane_1=0.
- Idle window after valid traffic -> lanes 0, valids 0, word_cnt unchanged; lanes stable across both cycles of every window.
- 130 windows of full pairs with CNT_WIDTH=8 -> word_cnt wraps from 0xFE through 0x00 to 0x04 after 260 words.
